// File: rtl/obstacle_lanes_mover_pkg.sv
// Shared screen geometry and timing constants for the game, plus lane direction type.
// The top-level game imports this package so every timed object agrees on the same values.
package obstacle_lanes_mover_pkg;

    localparam int DEF_N_LANES        = 4;
    localparam int DEF_H_VISIBLE_AREA = 640;
    localparam int DEF_TILE_SIZE      = 32;
    localparam int DEF_BASE_TICKS     = 781250;
    localparam int DEF_START_OFFSET   = 128;
    localparam int DEF_X_W            = 10;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // Rightmost legal tile-left-edge coordinate.
    function automatic int calc_x_max(input int h_visible, input int tile_size);
        return h_visible - tile_size;
    endfunction

endpackage

// File: rtl/obstacle_lanes_mover_if.sv
// Control and position bus between the game controller (master) and the lane mover (slave).
interface obstacle_lanes_mover_if #(
    parameter int N_LANES = 4,
    parameter int X_W     = 10
);
    logic                     i_Enable;
    logic                     i_Load;
    logic [2:0]               i_Level;
    logic [N_LANES-1:0]       i_Dir;
    logic [N_LANES*X_W-1:0]   o_Car_X;
    logic [N_LANES-1:0]       o_Step;
    logic [N_LANES-1:0]       o_Wrap;

    modport master (
        output i_Enable, i_Load, i_Level, i_Dir,
        input  o_Car_X, o_Step, o_Wrap
    );

    modport slave (
        input  i_Enable, i_Load, i_Level, i_Dir,
        output o_Car_X, o_Step, o_Wrap
    );
endinterface

// File: rtl/obstacle_lanes_mover_tick_prescaler.sv
// Free-running movement prescaler: one o_Tick every BASE_TICKS enabled cycles.
// Freezes with i_Enable low; i_Reset or i_Clear restarts a full period.
module tick_prescaler #(
    parameter int BASE_TICKS = 781250
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Tick
);
    localparam int CNT_W = $clog2(BASE_TICKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BASE_TICKS - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign o_Tick = (count_q == LAST) && i_Enable;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (o_Tick) begin
            count_d = '0;
        end else if (i_Enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/obstacle_lanes_mover.sv
// Multi-lane obstacle X position generator sharing one movement prescaler.
// Each lane steps left or right by i_Level+1 pixels per tick and wraps at the screen edges.
module obstacle_lanes_mover
    import obstacle_lanes_mover_pkg::*;
#(
    parameter int N_LANES        = DEF_N_LANES,
    parameter int H_VISIBLE_AREA = DEF_H_VISIBLE_AREA,
    parameter int TILE_SIZE      = DEF_TILE_SIZE,
    parameter int BASE_TICKS     = DEF_BASE_TICKS,
    parameter int START_OFFSET   = DEF_START_OFFSET,
    parameter int X_W            = DEF_X_W
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    obstacle_lanes_mover_if.slave bus
);
    localparam int X_MAX = calc_x_max(H_VISIBLE_AREA, TILE_SIZE);
    localparam logic [X_W:0] X_MAX_EXT = (X_W + 1)'(X_MAX);

    if (N_LANES < 1 || N_LANES > 8 || X_MAX < 8 || (N_LANES - 1) * START_OFFSET > X_MAX) begin : g_bad_cfg
        $error("obstacle_lanes_mover: illegal lane geometry");
    end

    logic         tick;
    logic [3:0]   step;
    logic [X_W:0] step_ext;

    tick_prescaler #(
        .BASE_TICKS (BASE_TICKS)
    ) u_prescaler (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Clear  (bus.i_Load),
        .i_Enable (bus.i_Enable),
        .o_Tick   (tick)
    );

    assign step     = {1'b0, bus.i_Level} + 4'd1;
    assign step_ext = (X_W + 1)'(step);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        localparam logic [X_W-1:0] START_X = X_W'(i * START_OFFSET);

        logic [X_W-1:0] x_q, x_d;
        logic [X_W:0]   x_ext;
        logic           wrap_d, wrap_q, step_q;

        // One extra bit keeps x + step from overflowing before the edge compare.
        assign x_ext = {1'b0, x_q};

        always_comb begin
            x_d    = x_q;
            wrap_d = 1'b0;
            if (dir_e'(bus.i_Dir[i]) == DIR_FWD) begin
                if (x_ext + step_ext > X_MAX_EXT) begin
                    x_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    x_d = X_W'(x_ext + step_ext);
                end
            end else begin
                if (x_ext < step_ext) begin
                    x_d    = X_MAX_EXT[X_W-1:0];
                    wrap_d = 1'b1;
                end else begin
                    x_d = X_W'(x_ext - step_ext);
                end
            end
        end

        always_ff @(posedge i_Clk) begin
            if (i_Reset || bus.i_Load) begin
                x_q    <= START_X;
                step_q <= 1'b0;
                wrap_q <= 1'b0;
            end else if (tick) begin
                x_q    <= x_d;
                step_q <= 1'b1;
                wrap_q <= wrap_d;
            end else begin
                step_q <= 1'b0;
                wrap_q <= 1'b0;
            end
        end

        assign bus.o_Car_X[i*X_W +: X_W] = x_q;
        assign bus.o_Step[i]             = step_q;
        assign bus.o_Wrap[i]             = wrap_q;
    end

endmodule

// File: tb/tb_obstacle_lanes_mover.sv
// Scoreboard bench for obstacle_lanes_mover: a behavioural model queues the expected
// outputs after every clock edge and a negedge monitor pops and compares them.
module tb_obstacle_lanes_mover;
    import obstacle_lanes_mover_pkg::*;

    localparam int N    = 4;
    localparam int XW   = 10;
    localparam int BT   = 4;
    localparam int SO   = 128;
    localparam int XMAX = 640 - 32;

    typedef struct packed {
        logic [N*XW-1:0] x;
        logic [N-1:0]    step;
        logic [N-1:0]    wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    obstacle_lanes_mover_if #(.N_LANES(N), .X_W(XW)) bus ();

    obstacle_lanes_mover #(
        .N_LANES        (N),
        .H_VISIBLE_AREA (640),
        .TILE_SIZE      (32),
        .BASE_TICKS     (BT),
        .START_OFFSET   (SO),
        .X_W            (XW)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   fwd_wraps  = 0;
    int   rev_wraps  = 0;
    int   collisions = 0;
    bit   running    = 1'b1;

    // Model state: enabled cycles since the last tick/restart, and plain integer positions.
    int m_pres;
    int m_x[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    always @(posedge clk) begin : model
        exp_t          e;
        logic [N-1:0]  st;
        logic [N-1:0]  wr;
        int            s;
        st = '0;
        wr = '0;
        if (rst || bus.i_Load) begin
            if (!rst && bus.i_Enable && m_pres == BT - 1) collisions++;
            m_pres = 0;
            for (int i = 0; i < N; i++) m_x[i] = i * SO;
        end else if (bus.i_Enable && m_pres == BT - 1) begin
            m_pres = 0;
            st     = '1;
            s      = int'(bus.i_Level) + 1;
            for (int i = 0; i < N; i++) begin
                if (bus.i_Dir[i] == 1'b0) begin
                    if (m_x[i] + s > XMAX) begin
                        m_x[i] = 0;
                        wr[i]  = 1'b1;
                        fwd_wraps++;
                    end else begin
                        m_x[i] = m_x[i] + s;
                    end
                end else begin
                    if (m_x[i] < s) begin
                        m_x[i] = XMAX;
                        wr[i]  = 1'b1;
                        rev_wraps++;
                    end else begin
                        m_x[i] = m_x[i] - s;
                    end
                end
            end
        end else if (bus.i_Enable) begin
            m_pres = m_pres + 1;
        end
        for (int i = 0; i < N; i++) e.x[i*XW +: XW] = XW'(m_x[i]);
        e.step = st;
        e.wrap = wr;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (running) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    check($sformatf("car_x[%0d]", i), 64'(bus.o_Car_X[i*XW +: XW]), 64'(e.x[i*XW +: XW]));
                end
                check("o_Step", 64'(bus.o_Step), 64'(e.step));
                check("o_Wrap", 64'(bus.o_Wrap), 64'(e.wrap));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_Enable = 1'b0;
        bus.i_Load   = 1'b0;
        bus.i_Level  = 3'd0;
        bus.i_Dir    = '0;
        m_pres       = 0;
        for (int i = 0; i < N; i++) m_x[i] = 0;

        // Reset, then first move at level 0 going right.
        cycle();
        cycle();
        rst          = 1'b0;
        bus.i_Enable = 1'b1;
        repeat (6) cycle();

        // Mixed directions, with a direction change between ticks.
        bus.i_Dir = 4'b1010;
        repeat (6) cycle();
        bus.i_Dir = 4'b0101;
        repeat (2) cycle();
        bus.i_Dir = 4'b1010;
        repeat (6) cycle();

        // Freeze mid-period.
        bus.i_Load = 1'b1;
        cycle();
        bus.i_Load = 1'b0;
        repeat (2) cycle();
        bus.i_Enable = 1'b0;
        repeat (10) cycle();
        bus.i_Enable = 1'b1;
        repeat (6) cycle();

        // Load landing on a tick edge, then reset and load together.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2 * BT && m_pres != BT - 1; w++) cycle();
            bus.i_Load = 1'b1;
            cycle();
            bus.i_Load = 1'b0;
            repeat (3) cycle();
        end
        rst        = 1'b1;
        bus.i_Load = 1'b1;
        cycle();
        rst        = 1'b0;
        bus.i_Load = 1'b0;
        repeat (2 * BT + 2) cycle();

        // Long randomized run: random levels every cycle, occasional direction, load and reset.
        repeat (16000) begin
            bus.i_Enable = ($urandom_range(0, 9) < 8);
            bus.i_Load   = ($urandom_range(0, 79) == 0);
            rst          = ($urandom_range(0, 399) == 0);
            bus.i_Level  = 3'($urandom);
            if ($urandom_range(0, 7) == 0) bus.i_Dir = N'($urandom);
            cycle();
        end
        rst          = 1'b0;
        bus.i_Load   = 1'b0;
        bus.i_Enable = 1'b0;
        repeat (2) cycle();

        @(negedge clk);
        #1;
        running = 1'b0;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("fwd_wrap_exercised", 64'(fwd_wraps > 0), 64'd1);
        check("rev_wrap_exercised", 64'(rev_wraps > 0), 64'd1);
        check("load_on_tick_exercised", 64'(collisions > 0), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_lanes_mover.md
Name: obstacle_lanes_mover

Overview:
Multi-lane obstacle position generator for the road/river section of the game screen. It drives N_LANES independent horizontal X coordinates from one shared speed prescaler. Each lane has its own run-time direction, and the step size is level-dependent. Outputs feed the sprite renderer and collision logic directly; positions are tile-left-edge pixel coordinates in the visible area.

Parameters:
N_LANES, 4, number of obstacle lanes (1..8)
H_VISIBLE_AREA, 640, visible pixels per line
TILE_SIZE, 32, obstacle sprite width in pixels
BASE_TICKS, 781250, clock cycles per movement tick (>= 2)
START_OFFSET, 128, reset/load X spacing between consecutive lanes
X_W, 10, width of each X coordinate

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous reset, active-high
i_Enable  in  1  1 = game running; 0 = freeze prescaler and all positions
i_Load  in  1  single-cycle pulse: restart lanes at start positions
i_Level  in  3  difficulty; step size = i_Level + 1 pixels per tick (1..8)
i_Dir  in  N_LANES  per-lane direction; bit i = 0 moves lane i right (+), 1 moves it left (-)
o_Car_X  out  N_LANES*X_W  packed X positions; lane i at bits [i*X_W +: X_W]
o_Step  out  N_LANES  one-cycle pulse per lane when its position changed
o_Wrap  out  N_LANES  one-cycle pulse per lane when its position wrapped

Behaviour:
- X_MAX = H_VISIBLE_AREA - TILE_SIZE (608 default). Elaboration constraint: (N_LANES-1)*START_OFFSET <= X_MAX and X_MAX >= 8.
- Reset (i_Reset=1 at an edge): prescaler = 0; lane i X = i*START_OFFSET; o_Step = 0; o_Wrap = 0. Reset applies regardless of i_Enable and i_Load.
- Priority per edge: reset > load > tick > hold.
- Load (i_Load=1, no reset): same register values as reset. It acts even when i_Enable=0.
- Prescaler: counts 0..BASE_TICKS-1 while i_Enable=1 and holds while i_Enable=0. tick = (count == BASE_TICKS-1) && i_Enable. The count returns to 0 on the tick edge, so ticks are exactly BASE_TICKS enabled cycles apart. The first tick after reset occurs on the BASE_TICKS-th enabled edge.
- On a tick edge, each lane i samples i_Dir[i] and i_Level on that same edge. With step = i_Level+1 (4-bit), X updates as follows:
  - forward: if X + step > X_MAX then X <= 0 and o_Wrap[i] = 1, else X <= X + step.
  - reverse: if X < step then X <= X_MAX and o_Wrap[i] = 1, else X <= X - step.
  - The comparison is done at X_W+1 bits so there is no overflow. Wrapping discards the excess distance; the lane always restarts exactly at the edge.
- o_Step[i] = 1 for the single cycle following every tick (all lanes) and is otherwise 0. o_Wrap[i] is a subset of o_Step[i]. Both pulses are registered and coincide with the updated o_Car_X value.
- Direction or level changes between ticks have no effect until the next tick. A direction flip at the X = 0 or X = X_MAX edge follows the same rules; for example, at X_MAX a flip to forward wraps to 0.
- Holding i_Enable low mid-period preserves the partial count; movement resumes with the remaining count.
- Reset or load in the same cycle as a tick: the reset/load values win, and o_Step/o_Wrap stay 0.
- Latency: positions change on the tick edge and are visible on the output one cycle after the tick condition. There is no combinational path from inputs to outputs.

Decomposition:
- Shared include file of localparams: H_VISIBLE_AREA, TILE_SIZE, X_MAX derivation, common timing constants. The top-level game reuses these.
- One sub-module, tick_prescaler (parameters BASE_TICKS; ports i_Clk, i_Reset, i_Clear, i_Enable, o_Tick), is reusable for other timed objects.
- Per-lane position update is a generate loop inside obstacle_lanes_mover; there is no separate lane module.

Test Plan:
1. Reset check, BASE_TICKS=4, N_LANES=4, START_OFFSET=128: assert i_Reset -> o_Car_X lanes = 0,128,256,384; o_Step = o_Wrap = 0. Hold i_Enable=1, i_Level=0, i_Dir=0 -> first move on the 4th edge to 1,129,257,385, with o_Step=4'b1111 for one cycle.
2. Forward wrap: lane 0 at 606, i_Level=2 (step 3), forward -> next X = 0, o_Wrap[0]=1 for one cycle. From 605 -> 608 with no wrap.
3. Reverse wrap: lane 1 at 2, i_Dir[1]=1, i_Level=7 (step 8) -> 608 with o_Wrap[1]=1. Next tick -> 600 with no wrap.
4. Freeze: i_Enable low for 10 cycles after 2 counts -> positions constant and no pulses. After re-enable, the move occurs exactly 2 cycles later.
5. Collision of events: i_Load on a tick cycle -> start positions, o_Step=0. i_Reset together with i_Load -> reset values, and the prescaler restarts a full BASE_TICKS period.
6. Per-lane direction: i_Dir=4'b1010 at i_Level=0 -> lanes 0 and 2 increment by 1 while lanes 1 and 3 decrement by 1 on the same tick. Change i_Dir between ticks -> no effect until the following tick.
